// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//
// Supervises an external UART frame FSM and buffers the bytes it receives.
// The controller arms the frame FSM (rx_clr pulse + rx_en), waits for a frame
// to complete, pushes good bytes into a small show-ahead FIFO and, after a
// stop-bit error, holds the frame FSM disabled for RECOVER_CYC cycles before
// re-arming it.
//
// Ports
//   clk, arst_n          single rising-edge clock, asynchronous active-low reset
//   enable               software receive enable
//   frame_done/frame_err frame FSM status; rx_data valid while frame_done=1
//   rx_en, rx_clr        frame FSM enable and one-cycle synchronous clear
//   rd_en, rd_data       FIFO pop request and show-ahead head byte
//   empty, full, level   FIFO status (registered-derived)
//   overrun              sticky: a received byte was dropped because FIFO full
//   err_cnt              saturating framing-error count
//   clr_stat             synchronous clear of overrun and err_cnt
//   state_dbg            current controller state, for observation only
//
// Read handshake: rd_data is valid whenever empty=0. A pop happens on a rising
// edge where rd_en=1 and empty=0; rd_en while empty=1 is ignored. empty/full
// depend only on registered level, so there is no path from rd_en to them.
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int RECOVER_CYC = 4
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          enable,
    input  logic                          frame_done,
    input  logic                          frame_err,
    input  logic [7:0]                    rx_data,
    output logic                          rx_en,
    output logic                          rx_clr,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overrun,
    output logic [7:0]                    err_cnt,
    input  logic                          clr_stat,
    output logic [2:0]                    state_dbg
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [3:0]    REC_LOAD  = 4'(RECOVER_CYC - 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    state_t          state_q,   state_d;
    logic [3:0]      rec_cnt_q, rec_cnt_d;
    logic [7:0]      byte_q,    byte_d;
    logic [AW-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [LW-1:0]   level_q,   level_d;
    logic            overrun_q, overrun_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            err_entry;
    logic            capture;
    logic            push;
    logic            pop;
    logic            overrun_set;
    logic            fifo_empty;
    logic            fifo_full;

    // ---------------------------------------------------------------------
    // Controller FSM: next state and Moore outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rec_cnt_d = rec_cnt_q;
        byte_d    = byte_q;
        rx_en     = 1'b0;
        rx_clr    = 1'b0;
        err_entry = 1'b0;
        capture   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_ARM;
            end
            S_ARM: begin
                rx_en   = 1'b1;
                rx_clr  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                rx_en = 1'b1;
                // Disable wins; an error wins over a simultaneous done.
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (frame_err) begin
                    state_d   = S_RECOVER;
                    rec_cnt_d = REC_LOAD;
                    err_entry = 1'b1;
                end else if (frame_done) begin
                    state_d = S_CAPTURE;
                    // rx_data is only guaranteed while frame_done=1, so it is
                    // held here for the push one cycle later.
                    byte_d  = rx_data;
                end
            end
            S_CAPTURE: begin
                rx_en   = 1'b1;
                capture = 1'b1;
                state_d = enable ? S_ARM : S_IDLE;
            end
            S_RECOVER: begin
                if (rec_cnt_q == 4'd0) begin
                    state_d = enable ? S_ARM : S_IDLE;
                end else begin
                    rec_cnt_d = rec_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // FIFO and status next-state
    // ---------------------------------------------------------------------
    always_comb begin
        fifo_empty  = (level_q == '0);
        fifo_full   = (level_q == LVL_FULL);
        pop         = rd_en && !fifo_empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push        = capture && (!fifo_full || pop);
        overrun_set = capture && fifo_full && !pop;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end

        // Set/increment events take priority over the software clear.
        overrun_d = overrun_q;
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (clr_stat) begin
            overrun_d = 1'b0;
        end

        err_cnt_d = err_cnt_q;
        if (err_entry) begin
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end else if (clr_stat) begin
            err_cnt_d = 8'h00;
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= S_IDLE;
            rec_cnt_q <= 4'd0;
            byte_q    <= 8'h00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            rec_cnt_q <= rec_cnt_d;
            byte_q    <= byte_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage needs no reset: rd_data is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= byte_q;
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign rd_data   = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
    assign empty     = fifo_empty;
    assign full      = fifo_full;
    assign level     = level_q;
    assign overrun   = overrun_q;
    assign err_cnt   = err_cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Bench for uart_rx_ctrl (FIFO_DEPTH=4, RECOVER_CYC=4). Inputs are driven 1ns
// after a rising edge and outputs are sampled 1ns after the following edge.
// The reference model is transaction level: a byte queue plus sticky overrun
// flag and saturating error counter, updated per frame / pop / clear.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    always #5 clk = ~clk;

    logic       enable = 1'b0;
    logic       frame_done = 1'b0;
    logic       frame_err = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       clr_stat = 1'b0;
    logic       rx_en;
    logic       rx_clr;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [2:0] level;
    logic       overrun;
    logic [7:0] err_cnt;
    logic [2:0] state_dbg;

    uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .RECOVER_CYC(4)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .enable     (enable),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .rx_data    (rx_data),
        .rx_en      (rx_en),
        .rx_clr     (rx_clr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .level      (level),
        .overrun    (overrun),
        .err_cnt    (err_cnt),
        .clr_stat   (clr_stat),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    logic       exp_over = 1'b0;
    logic [7:0] exp_err = 8'h00;
    int         errors = 0;
    int         checks = 0;

    typedef struct {
        logic       en;
        logic       done;
        logic [7:0] data;
        logic       rd;
        logic       x_rx_en;
        logic       x_rx_clr;
        logic       x_empty;
        logic [2:0] x_level;
        logic [7:0] x_rd_data;
    } vec_t;

    vec_t vecs[8];

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " rx_en"},   rx_en,   0);
        chk({tag, " rx_clr"},  rx_clr,  0);
        chk({tag, " empty"},   empty,   1);
        chk({tag, " full"},    full,    0);
        chk({tag, " level"},   level,   0);
        chk({tag, " overrun"}, overrun, 0);
        chk({tag, " err_cnt"}, err_cnt, 0);
        chk({tag, " rd_data"}, rd_data, 0);
    endtask

    task automatic check_model(input string tag);
        logic [7:0] head;
        head = (exp_q.size() == 0) ? 8'h00 : exp_q[0];
        chk({tag, " level"},   level,   exp_q.size());
        chk({tag, " empty"},   empty,   (exp_q.size() == 0));
        chk({tag, " full"},    full,    (exp_q.size() == DEPTH));
        chk({tag, " rd_data"}, rd_data, head);
        chk({tag, " overrun"}, overrun, exp_over);
        chk({tag, " err_cnt"}, err_cnt, exp_err);
    endtask

    // ---------------- driver tasks ----------------
    // From IDLE with enable=1: ARM then WAIT.
    task automatic go_wait();
        enable = 1'b1;
        tick();
        tick();
    endtask

    // Called with the DUT in WAIT; returns with the DUT back in WAIT.
    // pop asserts rd_en on the cycle the captured byte is pushed.
    task automatic frame(input logic [7:0] b, input logic err, input logic done, input logic do_pop);
        rx_data    = b;
        frame_err  = err;
        frame_done = done;
        tick();
        frame_err  = 1'b0;
        frame_done = 1'b0;
        rx_data    = 8'($urandom_range(0, 255));
        rd_en      = do_pop;
        tick();
        rd_en      = 1'b0;
        if (err) repeat (4) tick();
        else tick();
        if (do_pop && exp_q.size() > 0) void'(exp_q.pop_front());
        if (err) begin
            if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
        end else if (done) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else exp_over = 1'b1;
        end
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic clear_stats();
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        exp_over = 1'b0;
        exp_err  = 8'h00;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main test ----------------
    initial begin
        // Row: inputs for one cycle, outputs expected after the next edge.
        //            en    done  data   rd    rx_en rx_clr empty level rd_data
        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 8'h00}; // ARM
        vecs[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 8'h00}; // WAIT
        vecs[2] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 8'h00}; // CAPTURE
        vecs[3] = '{1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 8'hA5}; // ARM, pushed
        vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'hA5}; // WAIT
        vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 8'h00}; // popped
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00}; // IDLE
        vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00}; // pop on empty

        // Reset values while held in reset
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        arst_n = 1'b1;

        // Table-driven vectors: arm sequence and first byte latency
        for (int i = 0; i < 8; i++) begin
            enable     = vecs[i].en;
            frame_done = vecs[i].done;
            rx_data    = vecs[i].data;
            rd_en      = vecs[i].rd;
            tick();
            chk($sformatf("vec%0d rx_en", i),   rx_en,   vecs[i].x_rx_en);
            chk($sformatf("vec%0d rx_clr", i),  rx_clr,  vecs[i].x_rx_clr);
            chk($sformatf("vec%0d empty", i),   empty,   vecs[i].x_empty);
            chk($sformatf("vec%0d level", i),   level,   vecs[i].x_level);
            chk($sformatf("vec%0d rd_data", i), rd_data, vecs[i].x_rd_data);
        end
        frame_done = 1'b0;
        rd_en      = 1'b0;

        // Error with simultaneous done: no push, 4 cycles disabled, then re-arm
        go_wait();
        frame_err  = 1'b1;
        frame_done = 1'b1;
        rx_data    = 8'h77;
        tick();
        frame_err  = 1'b0;
        frame_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("recover%0d rx_en", i),  rx_en,  0);
            chk($sformatf("recover%0d rx_clr", i), rx_clr, 0);
            tick();
        end
        chk("rearm rx_clr", rx_clr, 1);
        chk("rearm rx_en",  rx_en,  1);
        tick();
        exp_err = 8'd1;
        check_model("err_done");

        // Five good frames into a depth-4 FIFO
        for (int i = 1; i <= 5; i++) frame(8'(i), 1'b0, 1'b1, 1'b0);
        check_model("fill5");
        chk("fill5 overrun set", overrun, 1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain head%0d", i), rd_data, i);
            pop_one();
        end
        check_model("drained");
        pop_one();
        check_model("pop_empty");

        // Full FIFO, capture concurrent with pop
        clear_stats();
        check_model("cleared");
        for (int i = 0; i < 4; i++) frame(8'h10 + 8'(i), 1'b0, 1'b1, 1'b0);
        frame(8'h99, 1'b0, 1'b1, 1'b1);
        check_model("full_push_pop");
        chk("full_push_pop overrun", overrun, 0);
        chk("full_push_pop head", rd_data, 8'h11);
        while (exp_q.size() > 0) begin
            chk("full_push_pop order", rd_data, exp_q[0]);
            pop_one();
        end
        check_model("drained2");

        // Error counter saturation and clear
        for (int i = 0; i < 300; i++) frame(8'h00, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        check_model("sat");
        chk("sat err_cnt", err_cnt, 255);
        clear_stats();
        check_model("sat_clr");

        // Randomized operations against the queue model
        for (int n = 0; n < 80; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                frame(8'($urandom_range(0, 255)), 1'b0, 1'b1, 1'($urandom_range(0, 3) == 0));
            end else if (op <= 6) begin
                frame(8'($urandom_range(0, 255)), 1'b1, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
            end else if (op <= 8) begin
                pop_one();
            end else begin
                clear_stats();
            end
            check_model($sformatf("rand%0d", n));
        end

        // Asynchronous reset in WAIT with two bytes buffered
        while (exp_q.size() > 0) pop_one();
        frame(8'hC1, 1'b0, 1'b1, 1'b0);
        frame(8'hC2, 1'b0, 1'b1, 1'b0);
        check_model("pre_reset");
        #2;
        arst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        exp_q.delete();
        exp_over = 1'b0;
        exp_err  = 8'h00;
        tick();
        tick();
        arst_n = 1'b1;
        go_wait();
        frame(8'h5E, 1'b0, 1'b1, 1'b0);
        check_model("post_reset");
        chk("post_reset head", rd_data, 8'h5E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
